// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle core: FSM states, instruction
// classes, opcode/OPX constants, instruction field positions and decode helpers.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADDI, I_ADD, I_SUB, I_LDW, I_STW,
    I_BR, I_BEQ, I_BLT, I_CALL, I_RET, I_ILL
  } instr_t;

  // Primary opcodes (IR[5:0])
  localparam logic [5:0] OP_CALL  = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] OP_STW   = 6'h15;
  localparam logic [5:0] OP_BLT   = 6'h16;
  localparam logic [5:0] OP_LDW   = 6'h17;
  localparam logic [5:0] OP_BEQ   = 6'h26;
  localparam logic [5:0] OP_RTYPE = 6'h3A;

  // Extended opcodes of the R-type group (IR[16:6])
  localparam logic [10:0] OPX_RET = 11'h0A0;  // 0x05 << 5
  localparam logic [10:0] OPX_ADD = 11'h620;  // 0x31 << 5
  localparam logic [10:0] OPX_SUB = 11'h720;  // 0x39 << 5

  // Field positions
  localparam int SRC1_LSB  = 27;
  localparam int SRC2_LSB  = 22;
  localparam int DEST_LSB  = 17;
  localparam int IMM16_LSB = 6;
  localparam int IMM26_LSB = 6;
  localparam int OPX_LSB   = 6;
  localparam int OP_LSB    = 0;

  function automatic logic [4:0] f_src1(input logic [31:0] ir);
    return ir[SRC1_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_src2(input logic [31:0] ir);
    return ir[SRC2_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_dest(input logic [31:0] ir);
    return ir[DEST_LSB +: 5];
  endfunction

  function automatic logic [25:0] f_imm26(input logic [31:0] ir);
    return ir[IMM26_LSB +: 26];
  endfunction

  function automatic logic [31:0] f_imm32(input logic [31:0] ir);
    logic [15:0] imm16;
    imm16 = ir[IMM16_LSB +: 16];
    return {{16{imm16[15]}}, imm16};
  endfunction

  function automatic logic [10:0] f_opx(input logic [31:0] ir);
    return ir[OPX_LSB +: 11];
  endfunction

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[OP_LSB +: 6];
  endfunction

  // Anything not listed here is illegal and stops the core.
  function automatic instr_t decode_instr(input logic [31:0] ir);
    instr_t cls;
    cls = I_ILL;
    case (f_op(ir))
      OP_CALL: cls = I_CALL;
      OP_ADDI: cls = I_ADDI;
      OP_BR:   cls = I_BR;
      OP_STW:  cls = I_STW;
      OP_BLT:  cls = I_BLT;
      OP_LDW:  cls = I_LDW;
      OP_BEQ:  cls = I_BEQ;
      OP_RTYPE: begin
        case (f_opx(ir))
          OPX_ADD: cls = I_ADD;
          OPX_SUB: cls = I_SUB;
          OPX_RET: cls = I_RET;
          default: cls = I_ILL;
        endcase
      end
      default: cls = I_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port,
// r0 reads as zero and ignores writes. Cleared by reset.
module cpu_mc_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // Register storage; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one memory port.
// ALU, PC and control live here; the register file is a sub-module.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LINK_REG = 31
) (
  input  logic        iClk,
  input  logic        nRst,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic        iMemReady,
  output logic        oHalt
);

  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  state_t             state, state_next;
  logic [31:0]        pc, ir, ra, rb, rz, ry;
  instr_t             instr;
  logic [31:0]        imm32;
  logic signed [31:0] ra_s, rb_s;
  logic               br_take;
  logic               mem_read, mem_write;
  logic [4:0]         rf_raddr_a, rf_waddr;
  logic [31:0]        rf_rdata_a, rf_rdata_b, rf_wdata;
  logic               rf_we;

  assign instr = decode_instr(ir);
  assign imm32 = f_imm32(ir);
  assign ra_s  = ra;
  assign rb_s  = rb;

  // Port A reads the link register during EXEC so ret can redirect the PC
  assign rf_raddr_a = (state == S_EXEC) ? LINK_ADDR : f_src1(ir);

  cpu_mc_regfile u_regfile (
    .clk     (iClk),
    .rst_n   (nRst),
    .raddr_a (rf_raddr_a),
    .raddr_b (f_src2(ir)),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // Branch condition from the operands latched in DECODE
  always_comb begin
    br_take = 1'b0;
    case (instr)
      I_BR:    br_take = 1'b1;
      I_BEQ:   br_take = (ra == rb);
      I_BLT:   br_take = (ra_s < rb_s);
      default: br_take = 1'b0;
    endcase
  end

  // Write-back target and value per instruction class
  always_comb begin
    rf_we    = (state == S_WB);
    rf_waddr = '0;
    rf_wdata = rz;
    case (instr)
      I_ADDI:       rf_waddr = f_src2(ir);
      I_ADD, I_SUB: rf_waddr = f_dest(ir);
      I_LDW: begin
        rf_waddr = f_src2(ir);
        rf_wdata = ry;
      end
      I_CALL:       rf_waddr = LINK_ADDR;
      default:      rf_we = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state and memory strobe decode
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (iMemReady) state_next = S_DECODE;
      end
      S_DECODE: state_next = (instr == I_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (instr)
          I_LDW, I_STW:                 state_next = S_MEM;
          I_ADDI, I_ADD, I_SUB, I_CALL: state_next = S_WB;
          default:                      state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (instr == I_LDW) mem_read  = 1'b1;
        else                mem_write = 1'b1;
        if (iMemReady) state_next = (instr == I_LDW) ? S_WB : S_FETCH;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an aborted access drops at once
  assign oMemRead  = nRst & mem_read;
  assign oMemWrite = nRst & mem_write;
  assign oMemAddr  = (state == S_FETCH) ? pc : rz;
  assign oMemData  = rb;
  assign oHalt     = (state == S_HALT);

  // Datapath registers: PC, IR, operand latches, ALU result and load data
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      pc <= RESET_PC;
      ir <= '0;
      ra <= '0;
      rb <= '0;
      rz <= '0;
      ry <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (iMemReady) begin
            ir <= iMemData;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          ra <= rf_rdata_a;
          rb <= rf_rdata_b;
        end
        S_EXEC: begin
          case (instr)
            I_ADDI, I_LDW, I_STW: rz <= ra + imm32;
            I_ADD:                rz <= ra + rb;
            I_SUB:                rz <= ra - rb;
            I_BR, I_BEQ, I_BLT: begin
              if (br_take) pc <= pc + imm32;
            end
            I_CALL: begin
              rz <= pc;
              pc <= {pc[31:28], f_imm26(ir), 2'b00};
            end
            I_RET:   pc <= rf_rdata_a;
            default: ;
          endcase
        end
        S_MEM: begin
          if (iMemReady && (instr == I_LDW)) ry <= iMemData;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboard bench for cpu_mc: an ISA-level model predicts every memory
// transaction (kind, address, store data, idle cycles before it) and the halt.
`timescale 1ns/1ps
module tb_cpu_mc;

  localparam int MW     = 1024;
  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_HALT = 2;

  localparam logic [5:0]  OPC_CALL = 6'h00, OPC_ADDI = 6'h04, OPC_BR  = 6'h06;
  localparam logic [5:0]  OPC_STW  = 6'h15, OPC_BLT  = 6'h16, OPC_LDW = 6'h17;
  localparam logic [5:0]  OPC_BEQ  = 6'h26, OPC_R    = 6'h3A, OPC_BAD = 6'h3F;
  localparam logic [10:0] X_ADD = 11'h620, X_SUB = 11'h720, X_RET = 11'h0A0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          idle;
  } exp_t;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] oMemAddr, oMemData, iMemData;
  logic        oMemRead, oMemWrite, iMemReady, oHalt;

  cpu_mc dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .oMemAddr  (oMemAddr),
    .oMemData  (oMemData),
    .iMemData  (iMemData),
    .oMemRead  (oMemRead),
    .oMemWrite (oMemWrite),
    .iMemReady (iMemReady),
    .oHalt     (oHalt)
  );

  always #5 iClk = ~iClk;

  logic [31:0] mem  [MW];   // memory seen by the DUT
  logic [31:0] mmem [MW];   // model's private copy
  logic [31:0] mr   [32];   // model register file
  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  bit          active     = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] enc_i(input int s1, input int s2, input int imm, input logic [5:0] op);
    return {5'(s1), 5'(s2), 16'(imm), op};
  endfunction

  function automatic logic [31:0] enc_r(input int s1, input int s2, input int d, input logic [10:0] opx);
    return {5'(s1), 5'(s2), 5'(d), opx, OPC_R};
  endfunction

  function automatic logic [31:0] enc_call(input int imm26);
    return {26'(imm26), OPC_CALL};
  endfunction

  function automatic void setr(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) mr[d] = v;
  endfunction

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input int idle);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.idle = idle;
    sb.push_back(e);
  endtask

  // Architectural model: executes instructions and records bus activity.
  task automatic run_model(input int steps);
    logic [31:0] pc, ir, va, vb, imm, ea;
    logic [4:0]  a, b, c;
    logic [10:0] opx;
    int          idle;
    bit          stop;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    pc = 32'd0; idle = 0; stop = 1'b0;
    for (int s = 0; s < steps && !stop; s++) begin
      push(K_RD, pc, 32'd0, idle);
      ir  = mmem[widx(pc)];
      pc  = pc + 32'd4;
      a   = ir[31:27]; b = ir[26:22]; c = ir[21:17]; opx = ir[16:6];
      imm = {{16{ir[21]}}, ir[21:6]};
      va  = mr[a]; vb = mr[b]; ea = va + imm;
      case (ir[5:0])
        OPC_ADDI: begin setr(b, ea); idle = 3; end
        OPC_LDW: begin
          push(K_RD, ea, 32'd0, 2);
          setr(b, mmem[widx(ea)]);
          idle = 1;
        end
        OPC_STW: begin
          push(K_WR, ea, vb, 2);
          mmem[widx(ea)] = vb;
          idle = 0;
        end
        OPC_BR:  begin pc = pc + imm; idle = 2; end
        OPC_BEQ: begin if (va == vb) pc = pc + imm; idle = 2; end
        OPC_BLT: begin if ($signed(va) < $signed(vb)) pc = pc + imm; idle = 2; end
        OPC_CALL: begin
          setr(5'd31, pc);
          pc = {pc[31:28], ir[31:6], 2'b00};
          idle = 3;
        end
        OPC_R: begin
          if (opx == X_ADD)      begin setr(c, va + vb); idle = 3; end
          else if (opx == X_SUB) begin setr(c, va - vb); idle = 3; end
          else if (opx == X_RET) begin pc = mr[31]; idle = 2; end
          else stop = 1'b1;
        end
        default: stop = 1'b1;
      endcase
      if (stop) push(K_HALT, 32'd0, 32'd0, 1);
    end
  endtask

  task automatic gen_directed();
    for (int i = 0; i < MW / 2; i++) mem[i] = {26'd0, OPC_BAD};
    for (int i = MW / 2; i < MW; i++) mem[i] = $urandom;
    mem[widx(32'h800)] = 32'hDEADBEEF;
    mem[widx(32'h00)] = enc_i(0, 2, 5, OPC_ADDI);        // r2 = 5
    mem[widx(32'h04)] = enc_i(0, 2, 32'h810, OPC_STW);   // [0x810] = 5
    mem[widx(32'h08)] = enc_i(0, 2, 32'h7F8, OPC_ADDI);  // r2 = 0x7F8
    mem[widx(32'h0C)] = enc_i(2, 3, 8, OPC_LDW);         // r3 = [0x800]
    mem[widx(32'h10)] = enc_i(0, 3, 0, OPC_STW);         // [0] = r3
    mem[widx(32'h14)] = enc_i(0, 1, -1, OPC_ADDI);       // r1 = -1
    mem[widx(32'h18)] = enc_i(0, 5, 1, OPC_ADDI);        // r5 = 1
    mem[widx(32'h1C)] = enc_i(1, 5, 4, OPC_BLT);         // taken -> 0x24
    mem[widx(32'h24)] = enc_i(5, 1, 4, OPC_BLT);         // not taken -> 0x28
    mem[widx(32'h28)] = enc_i(5, 5, 4, OPC_BEQ);         // taken -> 0x30
    mem[widx(32'h30)] = enc_i(0, 0, 4, OPC_BR);          // -> 0x38
    mem[widx(32'h38)] = enc_call(32'h40);                // -> 0x100, r31 = 0x3C
    mem[widx(32'h3C)] = enc_i(0, 31, 32'h814, OPC_STW);  // [0x814] = r31
    mem[widx(32'h100)] = enc_r(1, 5, 6, X_ADD);          // r6 = 0
    mem[widx(32'h104)] = enc_r(5, 1, 7, X_SUB);          // r7 = 2
    mem[widx(32'h108)] = enc_i(0, 7, 32'h818, OPC_STW);
    mem[widx(32'h10C)] = enc_i(0, 0, 32'h800, OPC_LDW);  // discarded
    mem[widx(32'h110)] = enc_r(0, 5, 4, X_ADD);          // r4 = 1
    mem[widx(32'h114)] = enc_i(0, 4, 32'h81C, OPC_STW);
    mem[widx(32'h118)] = enc_r(31, 0, 0, X_RET);         // -> 0x3C
  endtask

  function automatic logic [31:0] rand_instr(input bit ill);
    int p, r1, r2, rd, off;
    p   = $urandom_range(0, 99);
    r1  = $urandom_range(0, 7);
    r2  = $urandom_range(0, 7);
    rd  = $urandom_range(1, 7);
    off = 4 * (int'($urandom_range(0, 16)) - 8);
    if (ill && p < 2) return (p == 0) ? {26'($urandom), OPC_BAD} : enc_r(r1, r2, rd, 11'h7FF);
    if (p < 25) return enc_i(r1, rd, $urandom_range(0, 65535), OPC_ADDI);
    if (p < 38) return enc_r(r1, r2, rd, X_ADD);
    if (p < 48) return enc_r(r1, r2, rd, X_SUB);
    if (p < 58) return enc_i(0, r2, 32'h800 + 4 * $urandom_range(0, 511), OPC_LDW);
    if (p < 72) return enc_i(0, ($urandom_range(0, 4) == 0) ? 31 : r2,
                             32'h800 + 4 * $urandom_range(0, 511), OPC_STW);
    if (p < 76) return enc_i(r1, r2, off, OPC_BEQ);
    if (p < 80) return enc_i(r1, r2, off, OPC_BLT);
    if (p < 83) return enc_i(0, 0, off, OPC_BR);
    if (p < 87) return enc_call($urandom_range(0, 511));
    if (p < 90) return enc_r(31, 0, 0, X_RET);
    return enc_i(r1, rd, $urandom_range(0, 65535), OPC_ADDI);
  endfunction

  task automatic gen_random(input bit ill);
    for (int i = 0; i < MW / 2; i++) mem[i] = rand_instr(ill);
    for (int i = MW / 2; i < MW; i++) mem[i] = $urandom;
  endtask

  // Memory responder: random wait states, random iMemReady while idle
  initial begin : responder
    bit busy;
    int wl;
    busy = 1'b0; wl = 0;
    iMemReady = 1'b0; iMemData = '0;
    forever begin
      @(posedge iClk); #1;
      if (!nRst) begin
        busy = 1'b0; iMemReady = 1'b0;
      end else if (oMemRead || oMemWrite) begin
        if (!busy) begin
          busy = 1'b1;
          wl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3);
        end
        if (wl == 0) begin
          iMemReady = 1'b1;
          busy = 1'b0;
          if (oMemWrite) mem[widx(oMemAddr)] = oMemData;
          else           iMemData = mem[widx(oMemAddr)];
        end else begin
          wl--;
          iMemReady = 1'b0;
          iMemData = $urandom;
        end
      end else begin
        busy = 1'b0;
        iMemReady = 1'($urandom_range(0, 1));
        iMemData = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on each completed access or on halt
  initial begin : monitor
    int   idle;
    bit   halted;
    exp_t e;
    int   ak;
    logic [31:0] aa, ad;
    idle = 0; halted = 1'b0;
    forever begin
      @(negedge iClk);
      if (!nRst || !active) begin
        idle = 0; halted = 1'b0;
      end else if (oMemRead && oMemWrite) begin
        compared++; mismatched++;
        $display("FAIL strobes: read=1 write=1 at %0t, required at most one", $time);
      end else if (oMemRead || oMemWrite) begin
        if (halted) begin
          compared++; mismatched++;
          $display("FAIL halt_strobe: strobe during halt at %0t, required none", $time);
        end
        if (iMemReady) begin
          if (sb.size() > 0) begin
            e  = sb.pop_front();
            ak = oMemWrite ? K_WR : K_RD;
            aa = oMemAddr;
            ad = oMemWrite ? oMemData : 32'd0;
            compared++;
            if (ak != e.kind || aa !== e.addr || ad !== e.data || idle != e.idle) begin
              mismatched++;
              $display("FAIL txn: got kind=%0d addr=%h data=%h idle=%0d, required kind=%0d addr=%h data=%h idle=%0d",
                       ak, aa, ad, idle, e.kind, e.addr, e.data, e.idle);
            end
          end
          idle = 0;
        end
      end else if (oHalt) begin
        if (!halted) begin
          halted = 1'b1;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (e.kind != K_HALT || idle != e.idle) begin
              mismatched++;
              $display("FAIL halt: got kind=%0d idle=%0d, required kind=%0d addr=%h idle=%0d",
                       K_HALT, idle, e.kind, e.addr, e.idle);
            end
          end
        end
      end else begin
        idle++;
      end
    end
  end

  // Stimulus: episodes, each started by a reset that may cut an access short
  initial begin : stimulus
    int cyc;
    for (int ep = 0; ep < 11; ep++) begin
      @(posedge iClk); #2;
      active = 1'b0;
      nRst   = 1'b0;
      #1;
      compared++;
      if (oMemRead !== 1'b0 || oMemWrite !== 1'b0 || oHalt !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_outputs: read=%b write=%b halt=%b, required 0 0 0",
                 oMemRead, oMemWrite, oHalt);
      end
      repeat (2) @(posedge iClk);
      sb.delete();
      if (ep == 0) gen_directed();
      else         gen_random(ep % 3 == 0);
      for (int i = 0; i < MW; i++) mmem[i] = mem[i];
      run_model(150);
      @(negedge iClk); #2;
      active = 1'b1;
      nRst   = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 6000) begin
        @(negedge iClk);
        cyc++;
      end
      if (sb.size() > 0) begin
        compared++; mismatched++;
        $display("FAIL drain: episode %0d left %0d expected events, required 0", ep, sb.size());
      end
      repeat ($urandom_range(0, 4)) @(posedge iClk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
